// File: rtl/lw_sha_axi4_din_feeder_if.sv
// AXI4 write-channel bundle between the DIN feeder (master) and the SHA/HMAC slave top.
// Only the AW, W and B channels exist; the feeder never reads.
interface lw_sha_axi4_din_feeder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [11:0]           awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [3:0]            awid;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        output wdata, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        input  wdata, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lw_sha_axi4_din_feeder.sv
// Buffers message words from a valid/ready stream and pushes them into the SHA DIN
// register as FIXED-address AXI4 write bursts whenever the core requests DMA data.
//
// state | meaning
// IDLE  | waiting for dma_wr_req_i with words buffered; burst length latched on exit
// ADDR  | awvalid held with the latched awlen until awready
// DATA  | FIFO head presented on W, one pop per W handshake, wlast on final beat
// RESP  | bready high, waiting for the B response
module lw_sha_axi4_din_feeder #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [11:0] DIN_ADDR   = 12'h010,
    parameter int          FIFO_DEPTH = 8,
    parameter int          MAX_BURST  = 8,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_last,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          dma_wr_req_i,
    lw_sha_axi4_din_feeder_if.master      axi,
    output logic                          busy_o,
    output logic                          msg_done_o,
    output logic                          err_o,
    input  logic                          clear_err_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [LW-1:0]   level;

    logic [7:0]      awlen_q;
    logic [7:0]      beat_q;
    logic            has_last_q;
    logic            msg_done_q;
    logic            err_q;

    logic [7:0]      scan_len;
    logic            scan_last;

    logic            awvalid_c;
    logic            wvalid_c;
    logic            wlast_c;
    logic            bready_c;

    logic            push;
    logic            w_fire;
    logic            b_fire;
    logic            burst_start;

    assign s_ready     = (level < LW'(FIFO_DEPTH));
    assign push        = s_valid && s_ready;
    assign w_fire      = wvalid_c && axi.wready;
    assign b_fire      = bready_c && axi.bvalid;
    assign burst_start = (state_q == ST_IDLE) && (state_d == ST_ADDR);

    // FIFO storage: each entry is {s_last, s_data}
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {s_last, s_data};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (w_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, w_fire})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Burst length: leading words up to the first s_last tag, capped by level and MAX_BURST
    always_comb begin
        scan_len  = '0;
        scan_last = 1'b0;
        for (int i = 0; i < MAX_BURST; i++) begin
            if (!scan_last && (LW'(i) < level)) begin
                scan_len  = 8'(i);
                scan_last = mem[rd_ptr + PW'(i)][DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (dma_wr_req_i && (level != '0)) state_d = ST_ADDR;
            ST_ADDR: if (axi.awready) state_d = ST_DATA;
            ST_DATA: if (axi.wready && (beat_q == awlen_q)) state_d = ST_RESP;
            ST_RESP: if (axi.bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        wlast_c   = 1'b0;
        bready_c  = 1'b0;
        case (state_q)
            ST_ADDR: awvalid_c = 1'b1;
            ST_DATA: begin
                wvalid_c = 1'b1;
                wlast_c  = (beat_q == awlen_q);
            end
            ST_RESP: bready_c = 1'b1;
            default: ;
        endcase
    end

    // Burst bookkeeping and host-side status; an error response beats a same-cycle clear
    always_ff @(posedge aclk) begin
        if (areset) begin
            awlen_q    <= '0;
            beat_q     <= '0;
            has_last_q <= 1'b0;
            msg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            if (burst_start) begin
                awlen_q    <= scan_len;
                has_last_q <= scan_last;
                beat_q     <= '0;
            end else if (w_fire) begin
                beat_q <= beat_q + 8'd1;
            end
            if (b_fire) begin
                msg_done_q <= has_last_q;
            end
            if (b_fire && (axi.bresp != 2'b00)) begin
                err_q <= 1'b1;
            end else if (clear_err_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign axi.awaddr  = DIN_ADDR;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign axi.awburst = 2'b00;
    assign axi.awid    = AXI_ID;
    assign axi.awvalid = awvalid_c;
    assign axi.wdata   = wvalid_c ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    assign axi.wlast   = wlast_c;
    assign axi.wvalid  = wvalid_c;
    assign axi.bready  = bready_c;

    assign busy_o       = (state_q != ST_IDLE) || (level != '0);
    assign msg_done_o   = msg_done_q;
    assign err_o        = err_q;
    assign fifo_level_o = level;

endmodule

// File: tb/tb_lw_sha_axi4_din_feeder.sv
// Randomized bench for the DIN feeder: a queue-based transaction model checked every
// cycle, plus literal expectations on burst lengths, data order, status and reset.
module tb_lw_sha_axi4_din_feeder;
    localparam int          DW    = 32;
    localparam int          DEPTH = 8;
    localparam int          MAXB  = 8;
    localparam logic [11:0] DIN   = 12'h010;
    localparam logic [3:0]  ID    = 4'h5;

    localparam int PH_IDLE = 0;
    localparam int PH_ADDR = 1;
    localparam int PH_DATA = 2;
    localparam int PH_RESP = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;
    logic          dma_wr_req_i;
    logic          busy_o;
    logic          msg_done_o;
    logic          err_o;
    logic          clear_err_i;
    logic [3:0]    fifo_level_o;

    lw_sha_axi4_din_feeder_if #(.DATA_WIDTH(DW)) axi();

    lw_sha_axi4_din_feeder #(
        .DATA_WIDTH(DW), .DIN_ADDR(DIN), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB), .AXI_ID(ID)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .dma_wr_req_i(dma_wr_req_i), .axi(axi),
        .busy_o(busy_o), .msg_done_o(msg_done_o), .err_o(err_o),
        .clear_err_i(clear_err_i), .fifo_level_o(fifo_level_o)
    );

    always #5 aclk = ~aclk;

    int n_total = 0;
    int n_bad   = 0;

    bit stall_en   = 1'b0;
    bit slverr_en  = 1'b0;
    bit clear_on_b = 1'b0;
    bit clear_req  = 1'b0;
    bit b_pend     = 1'b0;

    int          w_beats  = 0;
    int          done_cnt = 0;
    logic [7:0]  aw_log[$];
    logic [31:0] w_log[$];

    logic [32:0] m_q[$];
    int          m_ph    = PH_IDLE;
    int          m_len   = 0;
    int          m_cnt   = 0;
    bit          m_hl    = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_total++;
        n_bad++;
        $display("FAIL timeout %s: event not seen, required within bound at %0t", name, $time);
    endtask

    // Per-cycle compare against the model, event logging, then model advance to the next edge
    always @(negedge aclk) begin : mon
        bit push_ok;
        bit err_set;
        if (m_valid) begin
            chk("s_ready", s_ready, m_q.size() < DEPTH);
            chk("fifo_level", fifo_level_o, m_q.size());
            chk("busy", busy_o, (m_ph != PH_IDLE) || (m_q.size() != 0));
            chk("awvalid", axi.awvalid, m_ph == PH_ADDR);
            chk("wvalid", axi.wvalid, m_ph == PH_DATA);
            chk("bready", axi.bready, m_ph == PH_RESP);
            chk("msg_done", msg_done_o, m_done);
            chk("err", err_o, m_err);
            if (m_ph == PH_ADDR) begin
                chk("awlen", axi.awlen, 8'(m_len - 1));
                chk("awaddr", axi.awaddr, DIN);
                chk("awburst", axi.awburst, 2'b00);
                chk("awsize", axi.awsize, 3'd2);
                chk("awid", axi.awid, ID);
            end
            if (m_ph == PH_DATA) begin
                chk("wdata", axi.wdata, m_q[0][31:0]);
                chk("wlast", axi.wlast, m_cnt == m_len - 1);
            end
        end
        if (m_valid && !areset) begin
            if (axi.awvalid && axi.awready) aw_log.push_back(axi.awlen);
            if (axi.wvalid && axi.wready) begin
                w_beats++;
                w_log.push_back(axi.wdata);
                if (axi.wlast) b_pend = 1'b1;
            end
            if (axi.bvalid && axi.bready) b_pend = 1'b0;
            if (msg_done_o) done_cnt++;
        end
        if (areset) begin
            m_q.delete();
            m_ph    = PH_IDLE;
            m_len   = 0;
            m_cnt   = 0;
            m_hl    = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            b_pend  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            push_ok = s_valid && (m_q.size() < DEPTH);
            err_set = 1'b0;
            m_done  = 1'b0;
            case (m_ph)
                PH_IDLE: if (dma_wr_req_i && m_q.size() > 0) begin
                    m_len = 0;
                    m_hl  = 1'b0;
                    for (int i = 0; i < m_q.size() && i < MAXB && !m_hl; i++) begin
                        m_len = i + 1;
                        if (m_q[i][32]) m_hl = 1'b1;
                    end
                    m_ph = PH_ADDR;
                end
                PH_ADDR: if (axi.awready) begin
                    m_ph  = PH_DATA;
                    m_cnt = 0;
                end
                PH_DATA: if (axi.wready) begin
                    void'(m_q.pop_front());
                    m_cnt++;
                    if (m_cnt == m_len) m_ph = PH_RESP;
                end
                default: if (axi.bvalid) begin
                    if (axi.bresp != 2'b00) err_set = 1'b1;
                    m_done = m_hl;
                    m_ph   = PH_IDLE;
                end
            endcase
            if (push_ok) m_q.push_back({s_last, s_data});
            if (err_set) m_err = 1'b1;
            else if (clear_err_i) m_err = 1'b0;
        end
    end

    // AXI slave responder
    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        clear_err_i = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            axi.awready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            axi.wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi.bvalid  = b_pend && (!stall_en || ($urandom_range(0, 1) == 1));
            axi.bresp   = slverr_en ? 2'b10 : 2'b00;
            clear_err_i = clear_req || (clear_on_b && axi.bvalid);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input bit l);
        bit ok;
        int t;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        t = 0;
        do begin
            ok = s_ready;
            tick();
            t++;
        end while (!ok && t < 500);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) fail_timeout("push");
    endtask

    task automatic fire();
        int n0;
        int t;
        n0 = aw_log.size();
        t  = 0;
        dma_wr_req_i = 1'b1;
        while (aw_log.size() == n0 && t < 500) begin
            tick();
            t++;
        end
        dma_wr_req_i = 1'b0;
        if (aw_log.size() == n0) fail_timeout("aw_handshake");
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        tick();
        while (busy_o && t < 1000) begin
            tick();
            t++;
        end
        if (busy_o) fail_timeout("idle");
        tick();
        tick();
    endtask

    task automatic chunk(input int n, input logic [31:0] base, input bit last_end);
        for (int i = 0; i < n; i++) push_word(base + 32'(i), last_end && (i == n - 1));
        fire();
        wait_idle();
    endtask

    initial begin : main
        int d0;
        int b0;
        int a0;
        int t;
        int words;
        bit stream_done;
        areset       = 1'b1;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        dma_wr_req_i = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        tick();

        chk("rst_awvalid", axi.awvalid, 1'b0);
        chk("rst_wvalid", axi.wvalid, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_level", fifo_level_o, 4'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_awaddr", axi.awaddr, 12'h010);
        chk("rst_awid", axi.awid, 4'h5);

        // three-word message in one burst
        d0 = done_cnt;
        b0 = w_log.size();
        chunk(3, 32'hA000_0000, 1'b1);
        chk("t1_awlen", aw_log[aw_log.size() - 1], 8'd2);
        chk("t1_w0", w_log[b0], 32'hA000_0000);
        chk("t1_w1", w_log[b0 + 1], 32'hA000_0001);
        chk("t1_w2", w_log[b0 + 2], 32'hA000_0002);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err_o, 1'b0);

        // 20-word message split 8/8/4
        d0 = done_cnt;
        b0 = w_beats;
        a0 = aw_log.size();
        chunk(8, 32'hB000_0000, 1'b0);
        chk("t2_done_after1", done_cnt - d0, 0);
        chunk(8, 32'hB000_0008, 1'b0);
        chk("t2_done_after2", done_cnt - d0, 0);
        chunk(4, 32'hB000_0010, 1'b1);
        chk("t2_done_after3", done_cnt - d0, 1);
        chk("t2_beats", w_beats - b0, 20);
        chk("t2_len0", aw_log[a0], 8'd7);
        chk("t2_len1", aw_log[a0 + 1], 8'd7);
        chk("t2_len2", aw_log[a0 + 2], 8'd3);

        // fill to full with no DMA request
        a0 = aw_log.size();
        for (int i = 0; i < 8; i++) push_word(32'hC000_0000 + 32'(i), i == 7);
        chk("t3_s_ready_full", s_ready, 1'b0);
        chk("t3_level_full", fifo_level_o, 4'd8);
        chk("t3_no_aw", aw_log.size() - a0, 0);
        chk("t3_awvalid_idle", axi.awvalid, 1'b0);
        b0 = w_beats;
        dma_wr_req_i = 1'b1;
        t = 0;
        while (w_beats == b0 && t < 200) begin
            tick();
            t++;
        end
        if (w_beats == b0) fail_timeout("t3_first_pop");
        chk("t3_s_ready_after_pop", s_ready, 1'b1);
        dma_wr_req_i = 1'b0;
        wait_idle();
        chk("t3_awlen", aw_log[a0], 8'd7);

        // random messages, random stalls, random DMA requests
        stall_en    = 1'b1;
        stream_done = 1'b0;
        d0    = done_cnt;
        b0    = w_beats;
        words = 0;
        fork
            begin
                for (int m = 0; m < 6; m++) begin
                    int len;
                    len = $urandom_range(1, 12);
                    for (int i = 0; i < len; i++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        push_word($urandom(), i == len - 1);
                        words++;
                    end
                end
                stream_done = 1'b1;
            end
            begin
                for (int c = 0; c < 20000 && !stream_done; c++) begin
                    dma_wr_req_i = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        dma_wr_req_i = 1'b1;
        wait_idle();
        dma_wr_req_i = 1'b0;
        stall_en = 1'b0;
        tick();
        chk("t4_done", done_cnt - d0, 6);
        chk("t4_beats", w_beats - b0, words);

        // SLVERR handling
        chunk(3, 32'hD000_0000, 1'b1);
        chk("t5_err_clean", err_o, 1'b0);
        d0 = done_cnt;
        slverr_en = 1'b1;
        chunk(2, 32'hD000_0010, 1'b1);
        slverr_en = 1'b0;
        chk("t5_err_set", err_o, 1'b1);
        chk("t5_done_on_err", done_cnt - d0, 1);
        repeat (5) tick();
        chk("t5_err_sticky", err_o, 1'b1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        chk("t5_err_cleared", err_o, 1'b0);
        slverr_en  = 1'b1;
        clear_on_b = 1'b1;
        chunk(2, 32'hD000_0020, 1'b1);
        slverr_en  = 1'b0;
        clear_on_b = 1'b0;
        chk("t5_err_wins_clear", err_o, 1'b1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();

        // reset in the middle of a five-beat burst
        for (int i = 0; i < 5; i++) push_word(32'hE000_0000 + 32'(i), i == 4);
        b0 = w_beats;
        dma_wr_req_i = 1'b1;
        t = 0;
        while ((w_beats - b0) < 2 && t < 200) begin
            tick();
            t++;
        end
        if ((w_beats - b0) < 2) fail_timeout("t6_two_beats");
        areset       = 1'b1;
        dma_wr_req_i = 1'b0;
        tick();
        chk("t6_wvalid", axi.wvalid, 1'b0);
        chk("t6_awvalid", axi.awvalid, 1'b0);
        chk("t6_level", fifo_level_o, 4'd0);
        chk("t6_busy", busy_o, 1'b0);
        areset = 1'b0;
        tick();
        d0 = done_cnt;
        b0 = w_log.size();
        chunk(2, 32'hF000_0000, 1'b1);
        chk("t6_after_done", done_cnt - d0, 1);
        chk("t6_after_awlen", aw_log[aw_log.size() - 1], 8'd1);
        chk("t6_after_w0", w_log[b0], 32'hF000_0000);
        chk("t6_after_w1", w_log[b0 + 1], 32'hF000_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
